// File: rtl/dbg_reg_dump_pkg.sv
// Shared definitions for the debug register-file dump sequencer.
// Data width default matches the global data width (32 bits).
package dbg_reg_dump_pkg;

  localparam int unsigned DefDw = 32;
  localparam int unsigned DefNreg = 32;
  localparam int unsigned DefIdxW = 5;

  localparam logic [7:0] CksResetVal = 8'h00;

  typedef enum logic [2:0] {
    StIdle,
    StSet,
    StCap,
    StSend,
    StCks,
    StDone
  } dump_state_e;

endpackage

// File: rtl/dbg_byte_serializer.sv
// Loads a DW-bit word and presents it LSB-first, one byte per valid/ready handshake.
// last_o pulses in the cycle the final byte of the word is accepted.
module dbg_byte_serializer
    import dbg_reg_dump_pkg::*;
#(
    parameter int unsigned DW = DefDw
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          load_i,
    input  logic [DW-1:0] word_i,
    output logic [7:0]    tx_data_o,
    output logic          tx_valid_o,
    input  logic          tx_ready_i,
    output logic          last_o
);

    localparam int unsigned NBytes = DW / 8;
    localparam int unsigned CntW   = (NBytes > 1) ? $clog2(NBytes) : 1;

    logic [DW-1:0]   shift_q, shift_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic            hs;

    assign hs         = valid_q && tx_ready_i;
    assign last_o     = hs && (cnt_q == CntW'(NBytes - 1));
    assign tx_data_o  = shift_q[7:0];
    assign tx_valid_o = valid_q;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            shift_d = word_i;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (hs) begin
            shift_d = shift_q >> 8;
            // Terminal compare precedes increment, so the counter never wraps.
            cnt_d   = last_o ? '0 : cnt_q + CntW'(1);
            valid_d = !last_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/dbg_reg_dump.sv
// Debug register-file dump sequencer: walks all registers and streams them byte-wise.
// Optional trailing XOR checksum byte when DBG_DUMP_CKSUM_EN is defined.
module dbg_reg_dump
    import dbg_reg_dump_pkg::*;
#(
    parameter int unsigned DW    = DefDw,
    parameter int unsigned NREG  = DefNreg,
    parameter int unsigned IDX_W = DefIdxW
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [IDX_W-1:0] dbg_reg_index_o,
    input  logic [DW-1:0]    dbg_reg_data_i,
    output logic [7:0]       tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i
);

    dump_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ser_load;
    logic [7:0]       ser_data;
    logic             ser_valid;
    logic             ser_last;

    dbg_byte_serializer #(
        .DW(DW)
    ) u_serializer (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .load_i    (ser_load),
        .word_i    (dbg_reg_data_i),
        .tx_data_o (ser_data),
        .tx_valid_o(ser_valid),
        .tx_ready_i(tx_ready_i),
        .last_o    (ser_last)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ser_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    idx_d   = '0;
                    state_d = StSet;
                end
            end
            StSet: state_d = StCap;
            StCap: begin
                ser_load = 1'b1;
                state_d  = StSend;
            end
            StSend: begin
                if (ser_last) begin
                    if (idx_q == IDX_W'(NREG - 1)) begin
`ifdef DBG_DUMP_CKSUM_EN
                        state_d = StCks;
`else
                        state_d = StDone;
`endif
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = StSet;
                    end
                end
            end
`ifdef DBG_DUMP_CKSUM_EN
            StCks: begin
                if (tx_ready_i) state_d = StDone;
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign busy_o          = (state_q != StIdle);
    assign done_o          = (state_q == StDone);
    assign dbg_reg_index_o = idx_q;

`ifdef DBG_DUMP_CKSUM_EN
    logic [7:0] cks_q, cks_d;

    always_comb begin
        cks_d = cks_q;
        if (state_q == StIdle && start_i) begin
            cks_d = CksResetVal;
        end else if (ser_valid && tx_ready_i) begin
            cks_d = cks_q ^ ser_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cks_q <= CksResetVal;
        end else begin
            cks_q <= cks_d;
        end
    end

    // The checksum byte is held by the (registered) CKS state until accepted.
    assign tx_valid_o = ser_valid || (state_q == StCks);
    assign tx_data_o  = (state_q == StCks) ? cks_q : ser_data;
`else
    assign tx_valid_o = ser_valid;
    assign tx_data_o  = ser_data;
`endif

endmodule
